// File: rtl/mdio_mem_rd_resp.sv
// -----------------------------------------------------------------------------
// mdio_mem_rd_resp
//
// Packet-control-domain responder for MDIO capture-memory read requests.
// A synchronized single-cycle read pulse latches an address and a 9-bit slice
// select. One memory word is then read and the selected slice is extracted.
// The slice is returned with a one-cycle valid strobe. After each response the
// block stays busy for GAP idle cycles so the return-path handshake back to the
// register domain can complete before another request is taken.
//
// Parameters
//   ADDR_W  capture-memory address width
//   NSLICE  9-bit slices per memory word (2..128); data width is 9*NSLICE
//   RD_LAT  memory read latency in cycles (1..7)
//   GAP     idle cycles after each response (0..255)
//
// Ports
//   pktctrl_clk     packet-control clock
//   pktctrl_rst     asynchronous active-high reset
//   rd_pulse        single-cycle read request
//   rd_addr         memory address of the request
//   rd_sel          slice select of the request
//   err_clr         clears drop_sticky and sel_err_sticky
//   mem_rd_en       one-cycle memory read strobe
//   mem_rd_addr     memory read address (holds the latched address)
//   mem_rd_data     memory read data, valid RD_LAT cycles after mem_rd_en
//   pkt_data        returned slice, held until the next response
//   pkt_data_vld    one-cycle strobe marking new pkt_data
//   busy            high whenever a request is in progress
//   drop_sticky     a request arrived while busy
//   sel_err_sticky  a request arrived with rd_sel >= NSLICE
// -----------------------------------------------------------------------------
module mdio_mem_rd_resp #(
   parameter int ADDR_W = 15,
   parameter int NSLICE = 96,
   parameter int RD_LAT = 2,
   parameter int GAP    = 8
) (
   input  logic                  pktctrl_clk,
   input  logic                  pktctrl_rst,
   input  logic                  rd_pulse,
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic [6:0]            rd_sel,
   input  logic                  err_clr,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_rd_addr,
   input  logic [9*NSLICE-1:0]   mem_rd_data,
   output logic [8:0]            pkt_data,
   output logic                  pkt_data_vld,
   output logic                  busy,
   output logic                  drop_sticky,
   output logic                  sel_err_sticky
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_RESP = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;

   localparam int         SEL_IW   = $clog2(NSLICE);
   localparam logic [7:0] NSLICE_W = 8'(NSLICE);
   localparam logic [7:0] LAT_LOAD = 8'(RD_LAT - 1);
   localparam logic [7:0] GAP_LOAD = 8'(GAP);

   logic [2:0]        state_q,  state_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [6:0]        sel_q,    sel_d;
   logic              sel_ok_q, sel_ok_d;
   logic [7:0]        cnt_q,    cnt_d;
   logic              en_q,     en_d;
   logic [8:0]        data_q,   data_d;
   logic              vld_q,    vld_d;
   logic              busy_q,   busy_d;
   logic              drop_q,   drop_d;
   logic              selerr_q, selerr_d;

   logic              rd_sel_ok;
   logic              drop_set;
   logic              selerr_set;
   logic [8:0]        slice_pick;

   // Split the memory word into its 9-bit slices so the select is a plain mux.
   logic [8:0] slice_w [NSLICE];
   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign slice_w[gi] = mem_rd_data[9*gi +: 9];
   end

   // The in-range flag is latched with the select so the mux never indexes
   // past the last slice; out-of-range selects return zero.
   assign slice_pick = sel_ok_q ? slice_w[sel_q[SEL_IW-1:0]] : 9'h000;
   assign rd_sel_ok  = ({1'b0, rd_sel} < NSLICE_W);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      sel_ok_d   = sel_ok_q;
      cnt_d      = cnt_q;
      en_d       = 1'b0;
      data_d     = data_q;
      vld_d      = 1'b0;
      selerr_set = 1'b0;
      drop_set   = rd_pulse && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (rd_pulse) begin
               addr_d     = rd_addr;
               sel_d      = rd_sel;
               sel_ok_d   = rd_sel_ok;
               selerr_set = !rd_sel_ok;
               en_d       = 1'b1;   // strobe is registered, so it is high in RD
               state_d    = ST_RD;
            end
         end
         ST_RD: begin
            cnt_d   = LAT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 8'd0) begin
               // Data is valid this cycle; vld is registered so it lands in RESP.
               data_d  = slice_pick;
               vld_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            if (GAP == 0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = GAP_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Entered with GAP loaded, so exiting at 1 gives exactly GAP cycles.
            if (cnt_q <= 8'd1) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d   = (state_d != ST_IDLE);
      // A set event in the same cycle as err_clr takes priority.
      drop_d   = drop_set   ? 1'b1 : (err_clr ? 1'b0 : drop_q);
      selerr_d = selerr_set ? 1'b1 : (err_clr ? 1'b0 : selerr_q);
   end

   always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
      if (pktctrl_rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         sel_q    <= '0;
         sel_ok_q <= 1'b0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         drop_q   <= 1'b0;
         selerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         sel_ok_q <= sel_ok_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
         selerr_q <= selerr_d;
      end
   end

   assign mem_rd_en      = en_q;
   assign mem_rd_addr    = addr_q;
   assign pkt_data       = data_q;
   assign pkt_data_vld   = vld_q;
   assign busy           = busy_q;
   assign drop_sticky    = drop_q;
   assign sel_err_sticky = selerr_q;

endmodule
